// File: rtl/pht_port_sched.sv
// Meta-predictor PHT port scheduler: shares one single-port SRAM between
// fetch-stage lookups and a queue of mem-stage 2-bit counter updates,
// and clears the table after reset.
module pht_port_sched #(
    parameter int unsigned IDX_W   = 10,
    parameter int unsigned Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pred_req,
    input  logic [31:0]      pred_pc,
    output logic             pred_ready,
    output logic             pred_valid,
    output logic             pred_sel,
    input  logic             upd_req,
    input  logic [31:0]      upd_pc,
    input  logic             upd_local,
    output logic             upd_ready,
    output logic             busy,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       mem_wdata,
    input  logic [1:0]       mem_rdata
);

    localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WB = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             to_local;
    } upd_entry_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pred_valid_q, pred_valid_d;
    logic             sel_hold_q, sel_hold_d;

    upd_entry_t       fifo_q [Q_DEPTH];
    upd_entry_t       head_c;
    upd_entry_t       push_entry_c;
    logic             q_full_c;
    logic             q_empty_c;
    logic             accept_c;
    logic             push_c;
    logic             pop_c;
    logic [1:0]       sat_c;
    logic             unused_c;

    // Only the low IDX_W PC bits index the table.
    assign unused_c = ^{pred_pc[31:IDX_W], upd_pc[31:IDX_W]};

    assign q_full_c     = (cnt_q == CNT_W'(Q_DEPTH));
    assign q_empty_c    = (cnt_q == CNT_W'(0));
    assign head_c       = fifo_q[rd_ptr_q];
    assign push_entry_c = {upd_pc[IDX_W-1:0], upd_local};

    // Saturating step of the counter read back for the head update.
    always_comb begin
        sat_c = mem_rdata;
        if (head_c.to_local) begin
            if (mem_rdata != 2'b11) sat_c = mem_rdata + 2'd1;
        end else begin
            if (mem_rdata != 2'b00) sat_c = mem_rdata - 2'd1;
        end
    end

    // Next-state and SRAM port arbitration.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 2'b00;
        pred_ready = 1'b0;
        upd_ready  = 1'b0;
        busy       = 1'b0;
        accept_c   = 1'b0;
        pop_c      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = 2'b01;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                pred_ready = ~q_full_c;
                upd_ready  = ~q_full_c;
                accept_c   = pred_req & ~q_full_c & ~stall;
                if (accept_c) begin
                    mem_rd   = 1'b1;
                    mem_addr = pred_pc[IDX_W-1:0];
                end else if (!q_empty_c) begin
                    mem_rd   = 1'b1;
                    mem_addr = head_c.idx;
                    state_d  = ST_UPD_WB;
                end
            end
            ST_UPD_WB: begin
                upd_ready = ~q_full_c;
                mem_wr    = 1'b1;
                mem_addr  = head_c.idx;
                mem_wdata = sat_c;
                pop_c     = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Keep the SRAM quiet while reset is asserted.
        if (!rst) begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 2'b00;
            accept_c  = 1'b0;
        end
    end

    // Update-queue pointer and occupancy bookkeeping.
    always_comb begin
        push_c   = upd_req & upd_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Selector returned the cycle after an accepted lookup, held otherwise.
    always_comb begin
        pred_valid   = pred_valid_q;
        pred_sel     = pred_valid_q ? mem_rdata[1] : sel_hold_q;
        pred_valid_d = accept_c;
        sel_hold_d   = pred_sel;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            pred_valid_q <= 1'b0;
            sel_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            pred_valid_q <= pred_valid_d;
            sel_hold_q   <= sel_hold_d;
        end
    end

    // Queue storage; validity is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= push_entry_c;
    end

endmodule

// File: tb/tb_pht_port_sched.sv
// Randomized bench for pht_port_sched with an SRAM model and a
// transaction-level reference of the counter table and update queue.
module tb_pht_port_sched;

    localparam int unsigned IDX_W = 10;
    localparam int unsigned QD    = 4;
    localparam int unsigned NENT  = 1 << IDX_W;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             pred_req;
    logic [31:0]      pred_pc;
    logic             pred_ready;
    logic             pred_valid;
    logic             pred_sel;
    logic             upd_req;
    logic [31:0]      upd_pc;
    logic             upd_local;
    logic             upd_ready;
    logic             busy;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [1:0]       mem_wdata;
    logic [1:0]       mem_rdata;

    pht_port_sched #(.IDX_W(IDX_W), .Q_DEPTH(QD)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .pred_req  (pred_req),
        .pred_pc   (pred_pc),
        .pred_ready(pred_ready),
        .pred_valid(pred_valid),
        .pred_sel  (pred_sel),
        .upd_req   (upd_req),
        .upd_pc    (upd_pc),
        .upd_local (upd_local),
        .upd_ready (upd_ready),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port SRAM: registered read data, write visible next cycle.
    bit [1:0] sram [NENT];
    initial mem_rdata = 2'b00;
    always @(posedge clk) begin
        if (mem_wr) sram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= sram[mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: counter table, pending updates, write-back phase.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             loc;
    } upd_t;

    bit [1:0]         ref_ctr [NENT];
    upd_t             q [$];
    bit               wb;
    logic [IDX_W-1:0] wb_idx;
    logic [1:0]       wb_val;
    bit               prev_acc;
    bit               exp_sel;

    function automatic logic [1:0] sat_step(input logic [1:0] v, input bit loc);
        int r;
        r = loc ? int'(v) + 1 : int'(v) - 1;
        if (r > 3) r = 3;
        if (r < 0) r = 0;
        return 2'(r);
    endfunction

    // Assert reset, check quiescent outputs, release and walk the clear sweep.
    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0; pred_req = 1'b0; pred_pc = '0;
        upd_req = 1'b0; upd_pc = '0; upd_local = 1'b0;
        #1;
        check("rst_mem", {mem_wr, mem_rd, mem_wdata, mem_addr}, 32'h0);
        check("rst_busy", busy, 1'b1);
        check("rst_pred", {pred_valid, pred_sel, pred_ready, upd_ready}, 4'b0000);
        q.delete();
        wb = 1'b0;
        prev_acc = 1'b0;
        exp_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < int'(NENT); i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("clear", {busy, mem_wr, mem_rd, pred_ready, upd_ready, mem_wdata, mem_addr},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, IDX_W'(i)});
        end
        for (int i = 0; i < int'(NENT); i++) ref_ctr[i] = 2'b01;
    endtask

    // One cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit preq, input logic [31:0] ppc, input bit st,
                        input bit ureq, input logic [31:0] upc, input bit ul);
        bit acc;
        int sz;
        logic [IDX_W-1:0] pidx;
        upd_t e;
        @(negedge clk);
        pred_req = preq; pred_pc = ppc; stall = st;
        upd_req = ureq; upd_pc = upc; upd_local = ul;
        #1;
        sz   = q.size();
        pidx = ppc[IDX_W-1:0];
        acc  = preq && !wb && (sz < int'(QD)) && !st;
        check("busy", busy, 1'b0);
        check("pred_ready", pred_ready, (!wb && sz < int'(QD)));
        check("upd_ready", upd_ready, (sz < int'(QD)));
        check("pred_valid", pred_valid, prev_acc);
        check("pred_sel", pred_sel, exp_sel);
        if (wb) begin
            check("wb_port", {mem_wr, mem_rd, mem_addr}, {1'b1, 1'b0, wb_idx});
            check("wb_data", mem_wdata, wb_val);
            void'(q.pop_front());
            wb = 1'b0;
        end else if (acc) begin
            check("rd_lookup", {mem_wr, mem_rd, mem_addr}, {1'b0, 1'b1, pidx});
            exp_sel = ref_ctr[pidx][1];
        end else if (sz > 0) begin
            check("rd_update", {mem_wr, mem_rd, mem_addr}, {1'b0, 1'b1, q[0].idx});
            wb_idx = q[0].idx;
            wb_val = sat_step(ref_ctr[q[0].idx], q[0].loc);
            ref_ctr[q[0].idx] = wb_val;
            wb = 1'b1;
        end else begin
            check("quiet", {mem_wr, mem_rd}, 2'b00);
        end
        if (ureq && sz < int'(QD)) begin
            e.idx = upc[IDX_W-1:0];
            e.loc = ul;
            q.push_back(e);
        end
        prev_acc = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // First lookup after the clear sweep sees weak-global.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b0);
        check("lk40_rd", {mem_rd, mem_addr}, {1'b1, 10'h040});
        idle(1);
        check("lk40_res", {pred_valid, pred_sel}, 2'b10);

        // Two toward-local updates saturate 1->2->3, third leaves it at 3.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        idle(4);
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        check("lk40_local", {pred_valid, pred_sel}, 2'b11);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        idle(4);
        check("ctr40_sat", sram[10'h040], 2'b11);

        // Stall blocks a lookup; dropping stall accepts it at once.
        step(1'b1, 32'h0000_0123, 1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_rd", mem_rd, 1'b0);
        idle(1);
        check("stall_pv", pred_valid, 1'b0);
        step(1'b1, 32'h0000_0123, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0123, 1'b0, 1'b0, 32'h0, 1'b0);
        check("unstall_rd", {mem_rd, mem_addr}, {1'b1, 10'h123});

        // Five updates while lookups keep the port busy: the fifth is dropped.
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0300 + 32'(k), 1'b0);
        check("full_upd_rdy", upd_ready, 1'b0);
        check("full_pred_rdy", pred_ready, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wb_pred_rdy", pred_ready, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drained_rdy", pred_ready, 1'b1);
        idle(12);
        check("q_order", {sram[10'h300], sram[10'h303], sram[10'h304]}, {2'b00, 2'b00, 2'b01});

        // Reset in the middle of a write-back with three entries queued.
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0020 + 32'(k), 1'b1);
        idle(1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("mid_wb", mem_wr, 1'b1);
        do_reset();
        idle(3);

        // Randomized traffic over a handful of colliding indices.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pp;
            logic [31:0] up;
            pp = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 7));
            up = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), pp, ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)));
        end
        idle(12);
        for (int i = 0; i < 8; i++) check("final_ctr", sram[i], ref_ctr[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pht_port_sched.md
PHT_PORT_SCHED -- requirements
Module: pht_port_sched

Interface
REQ-001 Parameter IDX_W, default 10, PHT index width; the table has 2**IDX_W entries.
REQ-002 Parameter Q_DEPTH, default 4, update-queue depth; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 stall  in  1  pipeline stall; when 1, no prediction lookup is accepted.
REQ-006 pred_req  in  1  fetch-stage meta-predictor lookup request.
REQ-007 pred_pc  in  32  lookup PC; index = pred_pc[IDX_W-1:0].
REQ-008 pred_ready  out  1  lookup can be accepted this cycle.
REQ-009 pred_valid  out  1  pred_sel is valid for the lookup accepted in the previous cycle.
REQ-010 pred_sel  out  1  selector: 1 = local predictor, 0 = global predictor.
REQ-011 upd_req  in  1  mem-stage update request.
REQ-012 upd_pc  in  32  update PC; index = upd_pc[IDX_W-1:0].
REQ-013 upd_local  in  1  1 = move the counter toward local; 0 = move it toward global.
REQ-014 upd_ready  out  1  an update can be enqueued this cycle.
REQ-015 busy  out  1  table clear in progress.
REQ-016 mem_addr  out  IDX_W  single-port PHT SRAM address.
REQ-017 mem_rd  out  1  SRAM read strobe; mem_rdata is valid on the following cycle.
REQ-018 mem_wr  out  1  SRAM write strobe; the written data is visible to a read issued on the next cycle.
REQ-019 mem_wdata  out  2  SRAM write data.
REQ-020 mem_rdata  in  2  SRAM read data.

Function
REQ-021 Counter encoding: 0 = strong global, 1 = weak global, 2 = weak local, 3 = strong local; pred_sel = counter bit 1.
REQ-022 The FSM has states CLEAR, IDLE and UPD_WB; mem_rd and mem_wr are never asserted in the same cycle.
REQ-023 CLEAR: write 2'b01 to address clr_cnt each cycle, clr_cnt counting 0 to 2**IDX_W-1; busy=1, pred_ready=0, upd_ready=0.
REQ-024 CLEAR to IDLE: in the cycle after the write to the last address; total CLEAR duration is exactly 2**IDX_W cycles.
REQ-025 Lookup accept = pred_req & pred_ready & ~stall; on accept, mem_rd=1 and mem_addr=pred index, and the state stays IDLE.
REQ-026 pred_ready = (state==IDLE) & ~queue_full.
REQ-027 The cycle after an accept: pred_valid=1 and pred_sel=mem_rdata[1]; otherwise pred_valid=0 and pred_sel holds its last value.
REQ-028 Update queue: FIFO of {index, upd_local}; enqueue on upd_req & upd_ready.
REQ-029 upd_ready = ~queue_full & (state!=CLEAR); an upd_req while upd_ready=0 is dropped.
REQ-030 IDLE with no lookup accepted and a non-empty queue: mem_rd=1, mem_addr=head index, go to UPD_WB.
REQ-031 UPD_WB: mem_wr=1, mem_addr=head index, mem_wdata=saturating mem_rdata+1 if head upd_local, else saturating mem_rdata-1 (3 stays 3, 0 stays 0); pop the head; return to IDLE.
REQ-032 Priority: a lookup wins over an update unless the queue is full; a full queue forces pred_ready=0, so the update proceeds.
REQ-033 Each update occupies the SRAM for exactly 2 cycles; lookups are not accepted in UPD_WB.
REQ-034 Enqueue and dequeue may occur in the same cycle; occupancy is then unchanged.
REQ-035 The FIFO pointers wrap modulo Q_DEPTH, with no lost or duplicated entries.
REQ-036 A lookup to an index with a pending queued update returns the pre-update counter; no forwarding is performed.

Reset
REQ-037 On rst=0 (asynchronous): state=CLEAR, clr_cnt=0, queue empty, pred_valid=0, pred_sel=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=1.
REQ-038 Reset asserted mid-operation discards all queued updates and any in-flight lookup; after release, CLEAR restarts from address 0.

Verification
REQ-039 Release reset, IDX_W=10 -> 1024 consecutive writes of 2'b01 to addresses 0..1023, busy=1 throughout, then IDLE with pred_ready=1.
REQ-040 After CLEAR, lookup at PC 0x40 -> mem_rd=1 with addr 0x040; the next cycle gives pred_valid=1, pred_sel=0.
REQ-041 Two upd_local=1 updates to PC 0x40, then a lookup -> counter 1->2->3, pred_sel=1; a third update leaves the counter at 3.
REQ-042 Five upd_req with no drain, Q_DEPTH=4, pred_req held -> fifth request dropped (upd_ready=0), pred_ready=0 until the queue drains below full.
REQ-043 pred_req with stall=1 -> no mem_rd and pred_valid stays 0; deasserting stall -> accepted the same cycle.
REQ-044 rst=0 pulse during UPD_WB with 3 entries queued -> mem_wr drops immediately, queue empty, CLEAR restarts at address 0.
